tiny_nn_link_test: RTL and testbench

// - Host-side initiator for the tiny_nn test-command protocol. Drives the 16-bit command word into

---
 rtl/tiny_nn_pkg.sv | 42 ++++
 rtl/tiny_nn_link_test_expect.sv | 27 ++
 rtl/tiny_nn_link_test.sv | 149 ++++++++++++++
 tb/tb_tiny_nn_link_test.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_nn_pkg.sv
// Shared tiny_nn constants and types used by the host-side link test initiator.
package tiny_nn_pkg;

  localparam logic [3:0] CmdOpTest    = 4'he;

  localparam logic [3:0] TestSubAscii = 4'hf;
  localparam logic [3:0] TestSubCount = 4'h1;
  localparam logic [3:0] TestSubPulse = 4'h0;
  localparam logic [3:0] TestSubNop   = 4'h2;

  localparam logic [15:0] CmdNop = {CmdOpTest, TestSubNop, 8'h00};

  localparam logic [7:0] TestHoldAscii = 8'hff;
  localparam logic [7:0] TestHoldPulse = 8'hf0;

  localparam logic [7:0] AsciiT     = 8'h54;
  localparam logic [7:0] AsciiDash  = 8'h2d;
  localparam logic [7:0] AsciiN     = 8'h4e;
  localparam logic [7:0] PulseEven  = 8'haa;
  localparam logic [7:0] PulseOdd   = 8'h55;
  localparam logic [7:0] IdleByte   = 8'hff;

  typedef enum logic [1:0] {
    LtModeAscii = 2'd0,
    LtModePulse = 2'd1,
    LtModeCount = 2'd2,
    LtModeRsvd  = 2'd3
  } link_test_mode_e;

  typedef enum logic [2:0] {
    LtFlush,
    LtIdle,
    LtCmd,
    LtRun,
    LtIdleChk
  } link_test_state_e;

  function automatic logic [15:0] test_cmd(input logic [3:0] sub, input logic [7:0] arg);
    return {CmdOpTest, sub, arg};
  endfunction

endpackage

// File: rtl/tiny_nn_link_test_expect.sv
// Expected byte returned by tiny_nn_top for a given test mode and byte index.
module tiny_nn_link_test_expect
  import tiny_nn_pkg::*;
(
  input  link_test_mode_e mode_i,
  input  logic [7:0]      idx_i,
  input  logic [7:0]      n_i,
  output logic [7:0]      byte_o
);

  always_comb begin
    byte_o = IdleByte;
    case (mode_i)
      LtModeAscii: begin
        case (idx_i[1:0])
          2'd0:    byte_o = AsciiT;
          2'd1:    byte_o = AsciiDash;
          default: byte_o = AsciiN;
        endcase
      end
      LtModePulse: byte_o = idx_i[0] ? PulseOdd : PulseEven;
      LtModeCount: byte_o = n_i - idx_i;
      default:     byte_o = IdleByte;
    endcase
  end

endmodule

// File: rtl/tiny_nn_link_test.sv
// Host-side tiny_nn test-command initiator: issues a test command, checks the
// returned byte stream plus the trailing idle byte, and reports pass/fail.
module tiny_nn_link_test
  import tiny_nn_pkg::*;
#(
  parameter int unsigned FlushCycles = 258
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic [7:0]  len_i,
  output logic [15:0] nn_data_o,
  input  logic [7:0]  nn_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [7:0]  err_count_o
);

  localparam int unsigned FlushW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
  localparam logic [FlushW-1:0] FlushLast = FlushW'(FlushCycles - 1);

  link_test_state_e  state_q;
  link_test_mode_e   mode_q;
  link_test_mode_e   mode_in;
  logic [FlushW-1:0] flush_q;
  logic [7:0]        n_q;
  logic [8:0]        last_q;
  logic [8:0]        idx_q;
  logic [7:0]        err_q;
  logic [7:0]        err_d;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [7:0]        exp_byte;
  logic              mismatch;

  assign mode_in = link_test_mode_e'(mode_i);

  tiny_nn_link_test_expect u_expect (
    .mode_i (mode_q),
    .idx_i  (idx_q[7:0]),
    .n_i    (n_q),
    .byte_o (exp_byte)
  );

  always_comb begin
    mismatch = 1'b0;
    if (state_q == LtRun)          mismatch = (nn_data_i != exp_byte);
    else if (state_q == LtIdleChk) mismatch = (nn_data_i != IdleByte);
    err_d = err_q;
    if (mismatch && (err_q != '1)) err_d = err_q + 8'd1;
  end

  // The final RUN cycle already drives CmdNop so the idle byte lands in IDLECHK.
  always_comb begin
    nn_data_o = CmdNop;
    case (state_q)
      LtCmd: begin
        case (mode_q)
          LtModeAscii: nn_data_o = test_cmd(TestSubAscii, 8'h00);
          LtModePulse: nn_data_o = test_cmd(TestSubPulse, 8'h00);
          LtModeCount: nn_data_o = test_cmd(TestSubCount, n_q);
          default:     nn_data_o = CmdNop;
        endcase
      end
      LtRun: begin
        if (idx_q != last_q) begin
          case (mode_q)
            LtModeAscii: nn_data_o = {TestHoldAscii, 8'h00};
            LtModePulse: nn_data_o = {TestHoldPulse, 8'h00};
            default:     nn_data_o = CmdNop;
          endcase
        end
      end
      default: nn_data_o = CmdNop;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LtFlush;
      mode_q  <= LtModeAscii;
      flush_q <= '0;
      n_q     <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LtFlush: begin
          if (flush_q == FlushLast) begin
            state_q <= LtIdle;
            busy_q  <= 1'b0;
          end else begin
            flush_q <= flush_q + 1'b1;
          end
        end
        LtIdle: begin
          if (start_i) begin
            err_q  <= '0;
            pass_q <= 1'b0;
            if (mode_in == LtModeRsvd) begin
              done_q <= 1'b1;
            end else begin
              state_q <= LtCmd;
              busy_q  <= 1'b1;
              mode_q  <= mode_in;
              n_q     <= len_i;
              idx_q   <= '0;
              // last_q holds L-1: N for COUNT, max(len,1)-1 otherwise.
              if (mode_in == LtModeCount)  last_q <= {1'b0, len_i};
              else if (len_i == 8'd0)      last_q <= '0;
              else                         last_q <= {1'b0, len_i - 8'd1};
            end
          end
        end
        LtCmd: state_q <= LtRun;
        LtRun: begin
          err_q <= err_d;
          idx_q <= idx_q + 9'd1;
          if (idx_q == last_q) state_q <= LtIdleChk;
        end
        LtIdleChk: begin
          err_q   <= err_d;
          state_q <= LtIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_d == '0);
        end
        default: begin
          state_q <= LtIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_tiny_nn_link_test.sv
// Bench for tiny_nn_link_test: behavioural tiny_nn responder with byte corruption,
// table-driven runs, randomized runs and hand-written reset/flush sequences.
module tb_tiny_nn_link_test;
  import tiny_nn_pkg::CmdOpTest;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode_in;
  logic [7:0]  len_in;
  logic [15:0] nn_data_o;
  logic [7:0]  nn_data_i;
  logic        busy_o, done_o, pass_o;
  logic [7:0]  err_count_o;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [15:0] NOP = {CmdOpTest, 4'h2, 8'h00};

  always #5 clk = ~clk;

  tiny_nn_link_test #(.FlushCycles(258)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .mode_i      (mode_in),
    .len_i       (len_in),
    .nn_data_o   (nn_data_o),
    .nn_data_i   (nn_data_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .err_count_o (err_count_o)
  );

  // ---------------- behavioural tiny_nn responder ----------------
  logic [15:0] word_seen = 16'h0000;
  logic [7:0]  cor [0:511];
  logic [7:0]  ascii_tbl [0:3];
  int rmode, rpos, rcnt, rk;
  logic [7:0] rb;

  always @(negedge clk) word_seen <= nn_data_o;

  initial begin
    ascii_tbl[0] = 8'h54; ascii_tbl[1] = 8'h2d; ascii_tbl[2] = 8'h4e; ascii_tbl[3] = 8'h4e;
    rmode = 0; rpos = 0; rcnt = 0; rk = 1000;
    nn_data_i = 8'hff;
    forever begin
      @(posedge clk);
      if (rst) begin
        rmode = 0; rb = 8'hff; rk = 1000;
      end else if (word_seen == {CmdOpTest, 4'hf, 8'h00}) begin
        rmode = 1; rb = ascii_tbl[0]; rpos = 1; rk = 0;
      end else if (word_seen == {CmdOpTest, 4'h0, 8'h00}) begin
        rmode = 2; rb = 8'haa; rpos = 1; rk = 0;
      end else if (word_seen[15:8] == {CmdOpTest, 4'h1}) begin
        rmode = 3; rcnt = int'(word_seen[7:0]); rb = word_seen[7:0]; rk = 0;
      end else if (word_seen == 16'hff00 && rmode == 1) begin
        rb = ascii_tbl[rpos % 4]; rpos++; rk++;
      end else if (word_seen == 16'hf000 && rmode == 2) begin
        rb = (rpos % 2 == 1) ? 8'h55 : 8'haa; rpos++; rk++;
      end else if (rmode == 3 && rcnt > 0) begin
        rcnt--; rb = 8'(rcnt); rk++;
      end else begin
        rmode = 0; rb = 8'hff; rk++;
      end
      if (rk >= 0 && rk < 512) rb = rb ^ cor[rk];
      nn_data_i <= rb;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int run_len(input int mode, input int len);
    if (mode == 2) return len + 1;
    return (len == 0) ? 1 : len;
  endfunction

  function automatic logic [15:0] exp_word(input int mode, input int len, input int L, input int k);
    if (k == 0) begin
      if (mode == 0) return {CmdOpTest, 4'hf, 8'h00};
      if (mode == 1) return {CmdOpTest, 4'h0, 8'h00};
      return {CmdOpTest, 4'h1, 8'(len)};
    end
    if (k < L && mode != 2) return (mode == 0) ? 16'hff00 : 16'hf000;
    return NOP;
  endfunction

  task automatic clear_cor();
    for (int i = 0; i < 512; i++) cor[i] = 8'h00;
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge where done_o is seen.
  task automatic do_run(input string tag, input int mode, input int len, input bit mid_start,
                        input int exp_cyc, input bit exp_pass, input int exp_err);
    int L, cyc, bad_w, bad_b;
    L = run_len(mode, len);
    start = 1'b1; mode_in = 2'(mode); len_in = 8'(len);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; bad_w = 0; bad_b = 0;
    while (cyc < 600 && done_o !== 1'b1) begin
      if (cyc <= L + 1) begin
        if (nn_data_o !== exp_word(mode, len, L, cyc)) bad_w++;
        if (busy_o !== 1'b1) bad_b++;
      end
      start = (mid_start && cyc == 100);
      mode_in = 2'd0; len_in = 8'd1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, " done cycle"}, cyc, L + 2);
    check({tag, " driven words"}, bad_w, 0);
    check({tag, " busy during run"}, bad_b, 0);
    check({tag, " pass"}, pass_o, exp_pass);
    check({tag, " err_count"}, err_count_o, exp_err);
    check({tag, " busy at done"}, busy_o, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " word"}, nn_data_o, NOP);
    check({tag, " busy"}, busy_o, 1);
    check({tag, " done"}, done_o, 0);
    check({tag, " pass"}, pass_o, 0);
    check({tag, " err"}, err_count_o, 0);
  endtask

  task automatic flush_and_check(input string tag);
    int cnt, bad_w;
    bit saw_done;
    cnt = 0; bad_w = 0; saw_done = 0;
    while (busy_o === 1'b1 && cnt < 1000) begin
      if (nn_data_o !== NOP) bad_w++;
      if (done_o === 1'b1) saw_done = 1;
      start = (cnt == 10); mode_in = 2'd0; len_in = 8'd1;
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check({tag, " flush length"}, cnt, 258);
    check({tag, " flush words"}, bad_w, 0);
    check({tag, " no done in flush"}, saw_done, 0);
    @(negedge clk);
    check({tag, " start in flush ignored"}, nn_data_o, NOP);
    check({tag, " idle after flush"}, busy_o, 0);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    len;
    int    cor_pos;    // -1: none
    logic [7:0] cor_val;
    bit    cor_all;
    bit    mid_start;
    int    exp_cyc;
    bit    exp_pass;
    int    exp_err;
  } vec_t;

  vec_t vecs [0:9];

  initial begin
    vecs[0] = '{"ascii6",      0, 6,   -1, 8'h00, 0, 0, 8,   1, 0};
    vecs[1] = '{"pulse0",      1, 0,   -1, 8'h00, 0, 0, 3,   1, 0};
    vecs[2] = '{"count3",      2, 3,   -1, 8'h00, 0, 0, 6,   1, 0};
    vecs[3] = '{"ascii4_bad2", 0, 4,    2, 8'h01, 0, 0, 6,   0, 1};
    vecs[4] = '{"ascii4_clean",0, 4,   -1, 8'h00, 0, 0, 6,   1, 0};
    vecs[5] = '{"pulse5_idle", 1, 5,    5, 8'h10, 0, 0, 7,   0, 1};
    vecs[6] = '{"count0",      2, 0,   -1, 8'h00, 0, 0, 3,   1, 0};
    vecs[7] = '{"count255_sat",2, 255, -1, 8'h01, 1, 0, 258, 0, 255};
    vecs[8] = '{"ascii1",      0, 1,   -1, 8'h00, 0, 0, 3,   1, 0};
    vecs[9] = '{"count255_mid",2, 255, -1, 8'h00, 0, 1, 258, 1, 0};

    rst = 1'b1; start = 1'b0; mode_in = 2'd0; len_in = 8'd0;
    clear_cor();
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;
    flush_and_check("por");

    foreach (vecs[i]) begin
      clear_cor();
      if (vecs[i].cor_all) begin
        for (int p = 0; p <= run_len(vecs[i].mode, vecs[i].len); p++) cor[p] = vecs[i].cor_val;
      end else if (vecs[i].cor_pos >= 0) begin
        cor[vecs[i].cor_pos] = vecs[i].cor_val;
      end
      do_run(vecs[i].name, vecs[i].mode, vecs[i].len, vecs[i].mid_start,
             vecs[i].exp_cyc, vecs[i].exp_pass, vecs[i].exp_err);
    end

    // Reserved mode, started in the done cycle of a passing run.
    clear_cor();
    start = 1'b1; mode_in = 2'd3; len_in = 8'd7;
    @(negedge clk);
    start = 1'b0;
    check("rsvd done", done_o, 1);
    check("rsvd pass", pass_o, 0);
    check("rsvd err", err_count_o, 0);
    check("rsvd busy", busy_o, 0);
    check("rsvd word", nn_data_o, NOP);
    @(negedge clk);
    check("rsvd done pulse", done_o, 0);

    // Randomized runs against the reference error count.
    for (int r = 0; r < 24; r++) begin
      int m, ln, L, nc, p1, p2;
      m  = $urandom_range(0, 2);
      ln = $urandom_range(0, 40);
      L  = run_len(m, ln);
      nc = $urandom_range(0, 2);
      clear_cor();
      p1 = $urandom_range(0, L);
      p2 = (p1 + 1 + $urandom_range(0, L - 1)) % (L + 1);
      if (nc >= 1) cor[p1] = 8'($urandom_range(1, 255));
      if (nc >= 2) cor[p2] = 8'($urandom_range(1, 255));
      do_run($sformatf("rand%0d_m%0d_l%0d", r, m, ln), m, ln, 0, L + 2, nc == 0, nc);
    end

    // Reset in the middle of a COUNT run.
    clear_cor();
    start = 1'b1; mode_in = 2'd2; len_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    check("mid count busy", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    flush_and_check("midrst");
    do_run("post_reset_ascii4", 0, 4, 0, 6, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
